fetch_unit: RTL

Front-end fetch stage that sits directly upstream of the combinational instruction ROM. It owns the program counter and drives the byte address to the ROM. It captures the returned 32-bit word together with its PC into a small in-order fetch queue, and presents entries to decode over a valid/ready handshake. Redirects from the back end (taken branch, mispredict recovery) flush the queue and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned INSTR_BYTES   = 4;
    localparam logic [63:0] PC_ALIGN_MASK = ~64'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetch entries with a synchronous flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               enq,
    input  fetch_entry_t       enq_data,
    input  logic               deq,
    output fetch_entry_t       head_data,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer/count update; enq+deq together leaves count unchanged even when full.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (enq && !flush) mem_q[tail_q] <= enq_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM and queues fetched words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned IMEM_SIZE   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_halted
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [63:0]      pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             out_of_range;
    logic             enq, deq;
    logic [CNT_W-1:0] count;
    fetch_entry_t     enq_data;
    fetch_entry_t     head_data;

    assign out_of_range = (pc_q + 64'd3) >= 64'(IMEM_SIZE);
    assign out_valid    = (count != '0);

    // A full queue may still accept when the head leaves this cycle.
    assign enq = !redirect_valid && !out_of_range && !halted_q &&
                 ((count < CNT_W'(QUEUE_DEPTH)) || (out_valid && out_ready));
    assign deq = out_valid && out_ready && !redirect_valid;

    assign enq_data = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q | out_of_range;
        if (redirect_valid) begin
            pc_d     = redirect_pc & PC_ALIGN_MASK;
            halted_d = 1'b0;
        end else if (enq) begin
            pc_d = pc_q + 64'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC & PC_ALIGN_MASK;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (deq),
        .head_data (head_data),
        .count     (count)
    );

    assign imem_addr    = pc_q;
    assign out_instr    = out_valid ? head_data.instr : '0;
    assign out_pc       = out_valid ? head_data.pc    : '0;
    assign fetch_halted = halted_q | out_of_range;

endmodule
